// File: rtl/gaussian_seq.sv
// rtl/gaussian_seq.sv - frame sequencer feeding 3x3 SDRAM windows through gaussianAccel
module gaussian_seq #(
    parameter int DIM_W      = 16,
    parameter int ACC_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    input  logic        m_waitrequest,
    output logic [3:0]  acc_addr,
    output logic        acc_wr_en,
    output logic        acc_rd_en,
    output logic [31:0] acc_writedata,
    input  logic [31:0] acc_readdata,
    output logic        irq
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAITD, S_LOAD, S_RDRES,
        S_RDWAIT, S_CAP, S_STORE, S_NEXT, S_DONE
    } state_t;

    state_t           state, state_next;
    logic [31:0]      src, dst, count, tap_data, result;
    logic [DIM_W-1:0] width, height, i, j;
    logic [3:0]       k;
    logic [7:0]       lat_cnt;
    logic             ie, done, err;
    logic             idle_like, busy, ctrl_wr, dims_ok, start_go, last_win;
    logic [1:0]       dx, dy;
    logic [31:0]      pix_idx, rd_addr, wr_addr;

    // DONE counts as idle so a start written in that cycle is not lost
    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign busy      = !idle_like;
    assign ctrl_wr   = wr_en && (addr == 3'd0);
    assign dims_ok   = (width >= DIM_W'(3)) && (height >= DIM_W'(3));
    assign start_go  = ctrl_wr && writedata[0] && idle_like && dims_ok;
    assign last_win  = (i == width - DIM_W'(3)) && (j == height - DIM_W'(3));
    assign irq       = done & ie;

    // Tap k of the window maps to column k%3, row k/3
    always_comb begin
        dx = 2'd0;
        dy = 2'd0;
        case (k)
            4'd1: dx = 2'd1;
            4'd2: dx = 2'd2;
            4'd3: dy = 2'd1;
            4'd4: begin dx = 2'd1; dy = 2'd1; end
            4'd5: begin dx = 2'd2; dy = 2'd1; end
            4'd6: dy = 2'd2;
            4'd7: begin dx = 2'd1; dy = 2'd2; end
            4'd8: begin dx = 2'd2; dy = 2'd2; end
            default: ;
        endcase
    end

    // Byte addresses wrap modulo 2^32 by construction
    assign pix_idx = (32'(j) + 32'(dy)) * 32'(width) + 32'(i) + 32'(dx);
    assign rd_addr = src + (pix_idx << 2);
    assign wr_addr = dst + (count << 2);

    // CSR read mux, combinational in the strobe cycle
    always_comb begin
        readdata = '0;
        if (rd_en) begin
            case (addr)
                3'd0: readdata = {29'b0, err, done, busy};
                3'd1: readdata = src;
                3'd2: readdata = dst;
                3'd3: readdata = 32'(width);
                3'd4: readdata = 32'(height);
                3'd5: readdata = count;
                default: readdata = '0;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state and bus/accelerator strobes
    always_comb begin
        state_next    = state;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_address     = '0;
        m_writedata   = '0;
        acc_addr      = '0;
        acc_wr_en     = 1'b0;
        acc_rd_en     = 1'b0;
        acc_writedata = '0;
        case (state)
            S_IDLE, S_DONE: state_next = start_go ? S_FETCH : S_IDLE;
            S_FETCH: begin
                m_read    = 1'b1;
                m_address = rd_addr;
                if (!m_waitrequest) state_next = S_WAITD;
            end
            S_WAITD: if (m_readdatavalid) state_next = S_LOAD;
            S_LOAD: begin
                acc_wr_en     = 1'b1;
                acc_addr      = k + 4'd1;
                acc_writedata = tap_data;
                state_next    = (k == 4'd8) ? S_RDRES : S_FETCH;
            end
            S_RDRES: begin
                acc_rd_en  = 1'b1;
                state_next = S_RDWAIT;
            end
            S_RDWAIT: if (lat_cnt == 8'(ACC_RD_LAT - 1)) state_next = S_CAP;
            S_CAP: state_next = S_STORE;
            S_STORE: begin
                m_write     = 1'b1;
                m_address   = wr_addr;
                m_writedata = result;
                if (!m_waitrequest) state_next = S_NEXT;
            end
            S_NEXT: state_next = last_win ? S_DONE : S_FETCH;
            default: state_next = S_IDLE;
        endcase
    end

    // CSRs, window indices and data latches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src      <= '0;
            dst      <= '0;
            width    <= '0;
            height   <= '0;
            count    <= '0;
            ie       <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            lat_cnt  <= '0;
            tap_data <= '0;
            result   <= '0;
        end else begin
            if (state == S_DONE) done <= 1'b1;
            if (wr_en) begin
                case (addr)
                    3'd0: begin
                        ie <= writedata[1];
                        if (writedata[2]) done <= 1'b0;
                        if (writedata[0] && idle_like) begin
                            if (dims_ok) begin
                                err   <= 1'b0;
                                done  <= 1'b0;
                                count <= '0;
                                i     <= '0;
                                j     <= '0;
                                k     <= '0;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    3'd1: if (!busy) src <= {writedata[31:2], 2'b00};
                    3'd2: if (!busy) dst <= {writedata[31:2], 2'b00};
                    3'd3: if (!busy) width <= writedata[DIM_W-1:0];
                    3'd4: if (!busy) height <= writedata[DIM_W-1:0];
                    default: ;
                endcase
            end
            case (state)
                S_WAITD:  if (m_readdatavalid) tap_data <= m_readdata;
                S_LOAD:   if (k != 4'd8) k <= k + 4'd1;
                S_RDRES:  lat_cnt <= '0;
                S_RDWAIT: lat_cnt <= lat_cnt + 8'd1;
                S_CAP:    result <= acc_readdata;
                S_STORE:  if (!m_waitrequest) count <= count + 32'd1;
                S_NEXT: begin
                    k <= '0;
                    if (i != width - DIM_W'(3)) begin
                        i <= i + DIM_W'(1);
                    end else begin
                        i <= '0;
                        j <= j + DIM_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gaussian_seq.sv
// tb/tb_gaussian_seq.sv - scoreboard bench for gaussian_seq with SDRAM and accelerator models
module tb_gaussian_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  addr = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;
    logic        m_readdatavalid = 1'b0;
    logic        m_waitrequest;
    logic [3:0]  acc_addr;
    logic        acc_wr_en;
    logic        acc_rd_en;
    logic [31:0] acc_writedata;
    logic [31:0] acc_readdata = '0;
    logic        irq;

    gaussian_seq #(.DIM_W(16), .ACC_RD_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
        .writedata(writedata), .readdata(readdata), .m_address(m_address),
        .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .m_waitrequest(m_waitrequest), .acc_addr(acc_addr), .acc_wr_en(acc_wr_en),
        .acc_rd_en(acc_rd_en), .acc_writedata(acc_writedata),
        .acc_readdata(acc_readdata), .irq(irq)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic [31:0] img [0:63];
    logic [31:0] taps [1:9];
    int          stall_cycles = 0;
    int          wait_cnt = 0;
    logic [31:0] rd_log [$];
    logic [63:0] wr_log [$];
    logic [63:0] exp_q [$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          stab_err = 0;
    logic        prev_stalled = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
    logic        prev_accrd = 1'b0, prev_accwr = 1'b0;
    logic [31:0] prev_addr = '0, prev_data = '0;
    logic [31:0] last_data = '0;
    logic [31:0] st;

    assign m_waitrequest = (m_read | m_write) && (wait_cnt < stall_cycles);

    // SDRAM slave: stall each command, answer reads one cycle after acceptance
    always @(posedge clk) begin
        if (!(m_read | m_write))  wait_cnt <= 0;
        else if (m_waitrequest)   wait_cnt <= wait_cnt + 1;
        else                      wait_cnt <= 0;
        if (m_read && !m_waitrequest) begin
            m_readdatavalid <= 1'b1;
            m_readdata      <= mem[m_address[11:2]];
            rd_log.push_back(m_address);
        end else begin
            m_readdatavalid <= 1'b0;
        end
        if (m_write && !m_waitrequest) wr_log.push_back({m_address, m_writedata});
    end

    function automatic logic [31:0] acc_model();
        logic [31:0] s = '0;
        for (int t = 1; t <= 9; t++) s += taps[t];
        return (s + taps[5]) / 10;
    endfunction

    // Accelerator: kernel [1 1 1;1 2 1;1 1 1]/10, result registered and held
    always @(posedge clk) begin
        if (acc_wr_en && acc_addr >= 4'd1 && acc_addr <= 4'd9) taps[acc_addr] <= acc_writedata;
        if (acc_rd_en) acc_readdata <= acc_model();
    end

    // Bus rule monitor: stall stability, no read+write, single-cycle acc strobes
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_stalled <= 1'b0;
            prev_accrd   <= 1'b0;
            prev_accwr   <= 1'b0;
        end else begin
            if ((prev_stalled && (m_read !== prev_rd || m_write !== prev_wr ||
                                  m_address !== prev_addr || m_writedata !== prev_data)) ||
                (m_read && m_write) ||
                (acc_rd_en && prev_accrd) || (acc_wr_en && prev_accwr))
                stab_err <= stab_err + 1;
            prev_stalled <= (m_read | m_write) & m_waitrequest;
            prev_rd      <= m_read;
            prev_wr      <= m_write;
            prev_addr    <= m_address;
            prev_data    <= m_writedata;
            prev_accrd   <= acc_rd_en;
            prev_accwr   <= acc_wr_en;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; writedata = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; rd_en = 1'b1;
        #1 d = readdata;
        rd_en = 1'b0;
    endtask

    function automatic logic [31:0] ref_out(input int w, input int i, input int j);
        logic [31:0] s = '0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                s += img[(j + dy) * w + i + dx];
        s += img[(j + 1) * w + i + 1];
        return s / 10;
    endfunction

    task automatic program_and_start(input int w, input int h, input logic [31:0] src,
                                     input logic [31:0] dst, input logic [31:0] ctrl);
        for (int n = 0; n < w * h; n++) mem[10'((src >> 2) + 32'(n))] = img[n];
        csr_write(3'd1, src);
        csr_write(3'd2, dst);
        csr_write(3'd3, 32'(w));
        csr_write(3'd4, 32'(h));
        rd_log.delete();
        wr_log.delete();
        exp_q.delete();
        for (int j = 0; j < h - 2; j++)
            for (int i = 0; i < w - 2; i++)
                exp_q.push_back({dst + 32'((j * (w - 2) + i) * 4), ref_out(w, i, j)});
        csr_write(3'd0, ctrl);
    endtask

    task automatic finish_frame(input string tag, input int w, input int h);
        logic [31:0] s;
        logic [63:0] e, g;
        bit to = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            csr_read(3'd0, s);
            if (s[1]) begin to = 1'b0; break; end
        end
        check({tag, "_timeout"}, 64'(to), 64'd0);
        check({tag, "_nwrites"}, 64'(wr_log.size()), 64'((w - 2) * (h - 2)));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (wr_log.size() > 0) g = wr_log.pop_front();
            else                   g = '1;
            check({tag, "_waddr"}, 64'(g[63:32]), 64'(e[63:32]));
            check({tag, "_wdata"}, 64'(g[31:0]), 64'(e[31:0]));
            last_data = g[31:0];
        end
    endtask

    // Directed sequence
    initial begin
        bit to;
        repeat (3) @(negedge clk);
        check("rst_strobes", 64'({m_read, m_write, acc_wr_en, acc_rd_en, irq}), 64'd0);
        check("rst_addr", 64'(m_address), 64'd0);
        reset_n = 1'b1;
        csr_read(3'd0, st);  check("rst_ctrl", 64'(st), 64'd0);
        csr_read(3'd5, st);  check("rst_count", 64'(st), 64'd0);

        // 3x3 ramp
        for (int n = 0; n < 9; n++) img[n] = 32'(n + 1);
        program_and_start(3, 3, 32'h100, 32'h200, 32'h1);
        finish_frame("t1", 3, 3);
        check("t1_value", 64'(last_data), 64'd5);
        csr_read(3'd0, st);  check("t1_ctrl", 64'(st), 64'h2);
        csr_read(3'd5, st);  check("t1_count", 64'(st), 64'd1);
        check("t1_nreads", 64'(rd_log.size()), 64'd9);
        for (int n = 0; n < 9 && n < rd_log.size(); n++)
            check("t1_tap_addr", 64'(rd_log[n]), 64'(32'h100 + 32'(4 * n)));

        // 3x3 with a bright centre
        img[4] = 32'd50;
        program_and_start(3, 3, 32'h100, 32'h200, 32'h1);
        finish_frame("t2", 3, 3);
        check("t2_value", 64'(last_data), 64'd14);

        // 4x4 flat frame, then interrupt enable and clear
        for (int n = 0; n < 16; n++) img[n] = 32'd255;
        program_and_start(4, 4, 32'h400, 32'h800, 32'h1);
        finish_frame("t3", 4, 4);
        check("t3_irq_off", 64'(irq), 64'd0);
        csr_write(3'd0, 32'h2);
        check("t3_irq_on", 64'(irq), 64'd1);
        csr_write(3'd0, 32'h6);
        check("t3_irq_clr", 64'(irq), 64'd0);
        csr_read(3'd0, st);  check("t3_ctrl", 64'(st), 64'd0);

        // undersized frame
        csr_write(3'd3, 32'd2);
        csr_write(3'd4, 32'd5);
        rd_log.delete();
        wr_log.delete();
        csr_write(3'd0, 32'h1);
        repeat (20) @(negedge clk);
        csr_read(3'd0, st);  check("t4_ctrl", 64'(st), 64'h4);
        check("t4_reads", 64'(rd_log.size()), 64'd0);
        check("t4_writes", 64'(wr_log.size()), 64'd0);

        // stalled bus on every command
        stall_cycles = 5;
        for (int n = 0; n < 16; n++) img[n] = 32'(n * 7 + 3);
        program_and_start(4, 4, 32'h100, 32'h300, 32'h1);
        finish_frame("t5", 4, 4);
        stall_cycles = 0;

        // reset during tap 4, then restart
        for (int n = 0; n < 9; n++) img[n] = 32'(n + 1);
        program_and_start(3, 3, 32'h100, 32'h200, 32'h3);
        to = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (m_read && m_address == 32'h110) begin to = 1'b0; break; end
        end
        check("t6_tap4_timeout", 64'(to), 64'd0);
        reset_n = 1'b0;
        #1;
        check("t6_strobes", 64'({m_read, m_write, acc_wr_en, acc_rd_en, irq, acc_addr}), 64'd0);
        check("t6_addr", 64'(m_address), 64'd0);
        check("t6_wdata", 64'(m_writedata), 64'd0);
        check("t6_accdata", 64'(acc_writedata), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        csr_read(3'd0, st);  check("t6_ctrl", 64'(st), 64'd0);
        csr_read(3'd1, st);  check("t6_src", 64'(st), 64'd0);
        csr_read(3'd5, st);  check("t6_count", 64'(st), 64'd0);
        program_and_start(3, 3, 32'h100, 32'h200, 32'h1);
        finish_frame("t6", 3, 3);
        check("t6_value", 64'(last_data), 64'd5);

        check("bus_rules", 64'(stab_err), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
